// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types and width helpers for the RGB fade sequencer.
package rgb_fade_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Slot index width and preset-count width for a given slot count.
  function automatic int slot_w(input int slots);
    return $clog2(slots);
  endfunction

  function automatic int cnt_w(input int slots);
    return $clog2(slots) + 1;
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_step_timer.sv
// Free-running divider that pulses tick once every DIV clocks; clear restarts it.
module step_timer #(
  parameter int DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || cnt_q == LAST) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Preset store plus PASS/FADE/HOLD sequencer driving three registered PWM levels.
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SLOTS      = 4,
  parameter int STEP_DIV   = 1024,
  parameter int HOLD_STEPS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         enc0,
  input  logic [WIDTH-1:0]         enc1,
  input  logic [WIDTH-1:0]         enc2,
  input  logic                     capture,
  input  logic                     play,
  output logic [WIDTH-1:0]         level0,
  output logic [WIDTH-1:0]         level1,
  output logic [WIDTH-1:0]         level2,
  output logic [$clog2(SLOTS):0]   slot_count,
  output logic [$clog2(SLOTS)-1:0] cur_slot,
  output logic                     busy
);

  localparam int SLOT_W = slot_w(SLOTS);
  localparam int CNT_W  = cnt_w(SLOTS);
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(SLOTS);

  // Channel 0 = red, 1 = green, 2 = blue.
  typedef logic [2:0][WIDTH-1:0] rgb_t;

  state_e            state_q, state_d;
  rgb_t              level_q, level_d;
  rgb_t              target_q, target_d;
  logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
  logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  slot_count_q, slot_count_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              busy_q, busy_d;
  logic              tick, timer_clear;
  logic [CNT_W-1:0]  slot_inc;
  logic [SLOT_W-1:0] next_slot;
  rgb_t              enc_rgb;
  rgb_t              slot_mem [SLOTS];

  assign enc_rgb = {enc2, enc1, enc0};

  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    if (cur < tgt)      return cur + WIDTH'(1);
    else if (cur > tgt) return cur - WIDTH'(1);
    else                return cur;
  endfunction

  // The divider idles in PASS and restarts on every state change.
  assign timer_clear = (state_q == ST_PASS) || (state_d != state_q);

  step_timer #(.DIV(STEP_DIV)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_PASS;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      ST_PASS: if (play && slot_count_q != '0) state_d = ST_FADE;
      ST_FADE: begin
        if (!play)                           state_d = ST_PASS;
        else if (tick && level_q == target_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!play)                              state_d = ST_PASS;
        else if (tick && hold_cnt_q == HOLD_LAST) state_d = ST_FADE;
      end
      default: state_d = ST_PASS;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    level_d    = level_q;
    target_d   = target_q;
    cur_slot_d = cur_slot_q;
    hold_cnt_d = hold_cnt_q;
    slot_inc   = CNT_W'(cur_slot_q) + CNT_W'(1);
    next_slot  = (slot_inc >= slot_count_q) ? '0 : slot_inc[SLOT_W-1:0];

    case (state_q)
      ST_PASS: begin
        level_d    = enc_rgb;
        cur_slot_d = '0;
        if (state_d == ST_FADE) target_d = slot_mem[0];
      end
      ST_FADE: begin
        if (state_d == ST_PASS)      cur_slot_d = '0;
        else if (state_d == ST_HOLD) hold_cnt_d = '0;
        else if (tick) begin
          for (int c = 0; c < 3; c++) level_d[c] = step_toward(level_q[c], target_q[c]);
        end
      end
      ST_HOLD: begin
        if (state_d == ST_PASS) cur_slot_d = '0;
        else if (state_d == ST_FADE) begin
          cur_slot_d = next_slot;
          target_d   = slot_mem[next_slot];
        end else if (tick) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: cur_slot_d = '0;
    endcase

    busy_d = (state_d == ST_FADE);
  end

  // Capture bookkeeping runs independently of the sequencer state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    slot_count_d = slot_count_q;
    if (capture) begin
      wr_ptr_d = wr_ptr_q + SLOT_W'(1);
      if (slot_count_q != CNT_FULL) slot_count_d = slot_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q      <= '0;
      target_q     <= '0;
      cur_slot_q   <= '0;
      wr_ptr_q     <= '0;
      slot_count_q <= '0;
      hold_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      level_q      <= level_d;
      target_q     <= target_d;
      cur_slot_q   <= cur_slot_d;
      wr_ptr_q     <= wr_ptr_d;
      slot_count_q <= slot_count_d;
      hold_cnt_q   <= hold_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // NOTE: preset storage has no reset; slot_count guards every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (capture) slot_mem[wr_ptr_q] <= enc_rgb;
  end

  assign level0     = level_q[0];
  assign level1     = level_q[1];
  assign level2     = level_q[2];
  assign slot_count = slot_count_q;
  assign cur_slot   = cur_slot_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a tick-arithmetic model.
module tb_rgb_fade_sequencer;

  localparam int WIDTH      = 8;
  localparam int SLOTS      = 4;
  localparam int STEP_DIV   = 4;
  localparam int HOLD_STEPS = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] enc0, enc1, enc2;
  logic             capture, play;
  logic [WIDTH-1:0] level0, level1, level2;
  logic [2:0]       slot_count;
  logic [1:0]       cur_slot;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: levels in a fade are start + k steps toward target,
  // clipped at the distance; segments are delimited by tick counts.
  int m_slot [SLOTS][3];
  int m_lvl [3];
  int m_start [3];
  int m_tgt [3];
  int m_count, m_wr, m_cur, m_cyc;
  bit m_active, m_fade;

  rgb_fade_sequencer #(
    .WIDTH(WIDTH), .SLOTS(SLOTS), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS)
  ) dut (
    .clk(clk), .reset(reset),
    .enc0(enc0), .enc1(enc1), .enc2(enc2),
    .capture(capture), .play(play),
    .level0(level0), .level1(level1), .level2(level2),
    .slot_count(slot_count), .cur_slot(cur_slot), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int toward(input int s, input int t, input int k);
    int d, mag, n;
    d   = t - s;
    mag = (d < 0) ? -d : d;
    n   = (k < mag) ? k : mag;
    return (d > 0) ? s + n : s - n;
  endfunction

  function automatic int fade_len();
    int mx, d;
    mx = 0;
    for (int c = 0; c < 3; c++) begin
      d = m_tgt[c] - m_start[c];
      if (d < 0) d = -d;
      if (d > mx) mx = d;
    end
    return mx + 1;
  endfunction

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_cur = 0; m_cyc = 0;
    m_active = 0; m_fade = 0;
    for (int c = 0; c < 3; c++) m_lvl[c] = 0;
  endtask

  task automatic model_edge(input bit cap, input bit pl, input int e0, input int e1, input int e2);
    int e [3];
    int k;
    e = '{e0, e1, e2};
    if (!m_active) begin
      m_lvl = e;
      m_cur = 0;
      if (pl && m_count >= 1) begin
        m_active = 1; m_fade = 1; m_cyc = 0;
        m_tgt = m_slot[0];
        m_start = e;
      end
    end else if (!pl) begin
      m_active = 0;
      m_cur = 0;
    end else begin
      m_cyc++;
      if (m_cyc % STEP_DIV == 0) begin
        k = m_cyc / STEP_DIV;
        if (m_fade) begin
          if (k == fade_len()) begin
            m_fade = 0; m_cyc = 0;
          end else begin
            for (int c = 0; c < 3; c++) m_lvl[c] = toward(m_start[c], m_tgt[c], k);
          end
        end else if (k == HOLD_STEPS) begin
          m_cur = (m_cur + 1) % m_count;
          m_start = m_lvl;
          m_tgt = m_slot[m_cur];
          m_fade = 1; m_cyc = 0;
        end
      end
    end
    if (cap) begin
      m_slot[m_wr] = e;
      m_wr = (m_wr + 1) % SLOTS;
      if (m_count < SLOTS) m_count++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("level0", 32'(level0), 32'(m_lvl[0]));
    check("level1", 32'(level1), 32'(m_lvl[1]));
    check("level2", 32'(level2), 32'(m_lvl[2]));
    check("slot_count", 32'(slot_count), 32'(m_count));
    check("cur_slot", 32'(cur_slot), 32'(m_cur));
    check("busy", 32'(busy), 32'(m_active && m_fade));
  endtask

  task automatic cyc(input bit cap, input bit pl, input int e0, input int e1, input int e2);
    capture = cap; play = pl;
    enc0 = 8'(e0); enc1 = 8'(e1); enc2 = 8'(e2);
    @(posedge clk);
    model_edge(cap, pl, e0, e1, e2);
    #1;
    check_all();
  endtask

  task automatic run(input int n, input bit pl);
    for (int i = 0; i < n; i++) cyc(1'b0, pl, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_level0", 32'(level0), 32'd0);
    check("rst_level1", 32'(level1), 32'd0);
    check("rst_level2", 32'(level2), 32'd0);
    check("rst_slot_count", 32'(slot_count), 32'd0);
    check("rst_cur_slot", 32'(cur_slot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit rp;
    reset = 1'b0; capture = 1'b0; play = 1'b0;
    enc0 = '0; enc1 = '0; enc2 = '0;
    #7;
    do_reset();

    // Reset in the middle of a fade at 0x37
    cyc(1'b1, 1'b0, 8'h80, 8'h80, 8'h80);
    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 0, 0, 0);
    run(220, 1'b1);
    check("mid_fade_l0", 32'(level0), 32'h37);
    check("mid_fade_l2", 32'(level2), 32'h37);
    check("mid_fade_busy", 32'(busy), 32'd1);
    do_reset();
    cyc(1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
    check("pass_l0", 32'(level0), 32'h10);
    check("pass_l1", 32'(level1), 32'h20);
    check("pass_l2", 32'(level2), 32'h30);

    // Single preset (5,0,FF): long fade, then 1-tick refade
    cyc(1'b1, 1'b0, 8'h05, 8'h00, 8'hFF);
    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 0, 0, 0);
    check("fade_busy_rise", 32'(busy), 32'd1);
    run(19, 1'b1);
    check("l0_after_19clk", 32'(level0), 32'd4);
    run(1, 1'b1);
    check("l0_after_20clk", 32'(level0), 32'd5);
    run(1000, 1'b1);
    check("l2_full", 32'(level2), 32'hFF);
    check("busy_before_hold", 32'(busy), 32'd1);
    run(4, 1'b1);
    check("busy_hold", 32'(busy), 32'd0);
    run(8, 1'b1);
    check("refade_busy", 32'(busy), 32'd1);
    check("refade_slot", 32'(cur_slot), 32'd0);
    run(4, 1'b1);
    check("refade_done", 32'(busy), 32'd0);
    check("l2_no_wrap", 32'(level2), 32'hFF);
    cyc(1'b0, 1'b0, 0, 0, 0);

    // Two presets A and B, cur_slot 0 -> 1 -> 0
    do_reset();
    cyc(1'b1, 1'b0, 10, 10, 10);
    cyc(1'b1, 1'b0, 12, 8, 10);
    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 200 && cur_slot != 2'd1; i++) run(1, 1'b1);
    check("ab_reach_slot1", 32'(cur_slot), 32'd1);
    check("ab_at_a", 32'(level0), 32'd10);
    run(8, 1'b1);
    check("ab_b_l0", 32'(level0), 32'd12);
    check("ab_b_l1", 32'(level1), 32'd8);
    check("ab_b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 200 && cur_slot != 2'd0; i++) run(1, 1'b1);
    check("ab_wrap_slot0", 32'(cur_slot), 32'd0);
    check("ab_wrap_busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 0, 0, 0);

    // Five captures into four slots, then capture during HOLD of slot 1
    do_reset();
    cyc(1'b1, 1'b0, 1, 2, 3);
    cyc(1'b1, 1'b0, 6, 5, 4);
    cyc(1'b1, 1'b0, 2, 2, 2);
    cyc(1'b1, 1'b0, 8, 0, 3);
    cyc(1'b1, 1'b0, 4, 4, 4);
    check("sat_count", 32'(slot_count), 32'd4);
    cyc(1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 100 && busy; i++) run(1, 1'b1);
    check("slot0_5th_l0", 32'(level0), 32'd4);
    check("slot0_5th_l2", 32'(level2), 32'd4);
    for (int i = 0; i < 200 && !(cur_slot == 2'd1 && !busy); i++) run(1, 1'b1);
    check("hold_slot1", 32'(cur_slot == 2'd1 && !busy), 32'd1);
    cyc(1'b1, 1'b1, 9, 9, 9);
    check("hold_keep_l0", 32'(level0), 32'd6);
    check("hold_keep_l1", 32'(level1), 32'd5);
    for (int i = 0; i < 200 && cur_slot != 2'd2; i++) run(1, 1'b1);
    for (int i = 0; i < 400 && !(cur_slot == 2'd1 && !busy); i++) run(1, 1'b1);
    check("revisit_slot1", 32'(cur_slot == 2'd1 && !busy), 32'd1);
    check("revisit_l0", 32'(level0), 32'd9);
    check("revisit_l2", 32'(level2), 32'd9);

    // Drop play mid-fade
    for (int i = 0; i < 100 && !busy; i++) run(1, 1'b1);
    check("fade_again", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_slot", 32'(cur_slot), 32'd0);
    cyc(1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
    check("stop_l0", 32'(level0), 32'h11);
    check("stop_l2", 32'(level2), 32'h33);

    // Random traffic
    rp = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 63) == 0) rp = !rp;
      cyc($urandom_range(0, 15) == 0, rp,
          int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
